computer_trace_monitor: RTL and testbench
=========================================

Name: computer_trace_monitor

Overview:
Synthesizable, parametrised successor to the computer bench's $monitor/$finish logic. Snoops the core's data-memory write bus and logs each store (pc, address, data) into a DEPTH-entry trace FIFO for later readout. An armed checker waits for one expected store and reports PASS, FAIL_DATA or FAIL_TIMEOUT within a programmable cycle budget. Sits beside `computer`, fed from its pc/instr/dataadr/writedata/memwrite nets.

Parameters:
DWIDTH, 8, width of pc, dataadr and writedata.
IWIDTH, 16, width of instr.
DEPTH, 16, trace FIFO entries; power of two, minimum 2.
TWIDTH, 10, width of the timeout budget and cycle counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  snoop enable; 0 = no trace pushes and checker counter frozen
pc  in  DWIDTH  core program counter
instr  in  IWIDTH  core instruction (used only with TRACE_INSTR_EN)
memwrite  in  1  core store strobe
dataadr  in  DWIDTH  store address
writedata  in  DWIDTH  store data
arm  in  1  one-cycle pulse: latch exp_adr/exp_data/budget, start check
exp_adr  in  DWIDTH  expected store address
exp_data  in  DWIDTH  expected store data
budget  in  TWIDTH  cycles allowed after arm
clear  in  1  return checker to IDLE, clear overflow
rd_en  in  1  pop one trace entry
rd_data  out  ENTRY_W  {pc, dataadr, writedata}, pc in MSBs
rd_valid  out  1  rd_data valid this cycle
count  out  $clog2(DEPTH+1)  entries held
overflow  out  1  sticky: a store was dropped while full
status  out  2  00 IDLE, 01 ARMED, 10 PASS, 11 FAIL
fail_timeout  out  1  with status=11: 1 timeout, 0 data mismatch

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, rd_data=0, rd_valid=0, overflow=0, status=00, fail_timeout=0, counter=0.
- ENTRY_W = 3*DWIDTH (+IWIDTH with TRACE_INSTR_EN).
- Push: en=1 and memwrite=1 at a rising edge -> entry written; count+1 same edge. Full and no pop -> entry dropped, overflow set.
- Pop: rd_en=1 and count>0 -> rd_data registered with oldest entry, rd_valid=1 the next cycle only. rd_en on empty ignored; rd_valid=0; rd_data holds.
- Push and pop in the same cycle: both accepted, including when full (no drop, count unchanged) and when empty (pop ignored, push accepted).
- Pointers wrap modulo DEPTH; count saturates at DEPTH.
- Checker FSM: IDLE --arm--> ARMED (latch exp_*, budget; counter=0). arm ignored outside IDLE.
- ARMED, each en=1 cycle: memwrite && dataadr==exp_adr -> PASS if writedata==exp_data, else FAIL (fail_timeout=0). Stores to other addresses ignored. Without a match, counter+1; counter==budget-1 with no match -> FAIL (fail_timeout=1). Match and expiry in the same cycle -> match wins. budget=0 is treated as 1.
- PASS/FAIL hold until clear. clear in any state -> IDLE next edge, fail_timeout=0, overflow=0; FIFO contents kept. clear and arm together -> clear wins.
- status changes on the edge after the deciding cycle (1-cycle latency).
- Reset asserted mid-check or mid-readout aborts immediately to reset values.

Optional Feature:
TRACE_INSTR_EN: when defined, each entry also stores instr (placed between pc and dataadr) and ENTRY_W = 3*DWIDTH+IWIDTH. When undefined, instr is unconnected internally, ENTRY_W = 3*DWIDTH, and no instr storage is built.

Test Plan:
- Reset then arm exp_adr=84, exp_data=7, budget=100; drive a store 84<-7 at cycle 10 -> status 10 one cycle later, count=1, rd_data={pc,84,7}.
- Arm with exp_adr=84, exp_data=7; drive a store 84<-5 -> status 11, fail_timeout=0; a store 80<-7 earlier leaves status 01.
- Arm with budget=5 and no stores -> status 11, fail_timeout=1 exactly 5 cycles after arm; clear -> status 00.
- Push 17 stores with DEPTH=16 and no reads -> count=16, overflow=1; popping 16 times returns stores 1..16 in order, rd_valid high one cycle each.
- With the FIFO full, assert push and rd_en together -> count stays 16, overflow stays 0, the oldest entry is emitted.
- Pull reset low while ARMED with count=3 -> status 00, count 0, rd_valid 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/computer_trace_monitor.sv
// Store-trace FIFO and single-store checker that sit beside the core.
// Optional TRACE_INSTR_EN adds the instruction word to every trace entry.
module computer_trace_monitor #(
    parameter int DWIDTH = 8,
    parameter int IWIDTH = 16,
    parameter int DEPTH  = 16,
    parameter int TWIDTH = 10,
`ifdef TRACE_INSTR_EN
    localparam int ENTRY_W = 3*DWIDTH + IWIDTH,
`else
    localparam int ENTRY_W = 3*DWIDTH,
`endif
    localparam int CWIDTH = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [DWIDTH-1:0]  pc,
    input  logic [IWIDTH-1:0]  instr,
    input  logic               memwrite,
    input  logic [DWIDTH-1:0]  dataadr,
    input  logic [DWIDTH-1:0]  writedata,
    input  logic               arm,
    input  logic [DWIDTH-1:0]  exp_adr,
    input  logic [DWIDTH-1:0]  exp_data,
    input  logic [TWIDTH-1:0]  budget,
    input  logic               clear,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [CWIDTH-1:0]  count,
    output logic               overflow,
    output logic [1:0]         status,
    output logic               fail_timeout
);

    localparam int AWIDTH = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_PASS  = 2'b10,
        S_FAIL  = 2'b11
    } state_t;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry;
    logic [AWIDTH-1:0]  wr_ptr, rd_ptr;
    logic               full, push_req, push, pop, drop;

`ifdef TRACE_INSTR_EN
    assign entry = {pc, instr, dataadr, writedata};
`else
    logic unused_instr;
    assign unused_instr = ^instr;
    assign entry = {pc, dataadr, writedata};
`endif

    // A full FIFO still accepts a store when the same cycle pops the oldest entry.
    assign full     = (count == CWIDTH'(DEPTH));
    assign push_req = en && memwrite;
    assign pop      = rd_en && (count != '0);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // NOTE: the trace storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) wr_ptr <= wr_ptr + AWIDTH'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AWIDTH'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CWIDTH'(1);
                2'b01:   count <= count - CWIDTH'(1);
                default: count <= count;
            endcase
            if (clear)     overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

    state_t             state, state_d;
    logic [TWIDTH-1:0]  counter, counter_d;
    logic [TWIDTH-1:0]  budget_q;
    logic [DWIDTH-1:0]  exp_adr_q, exp_data_q;
    logic               fail_timeout_d, load_exp;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state;
        counter_d      = counter;
        fail_timeout_d = fail_timeout;
        load_exp       = 1'b0;
        if (clear) begin
            state_d        = S_IDLE;
            fail_timeout_d = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state_d   = S_ARMED;
                        counter_d = '0;
                        load_exp  = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (en) begin
                        if (memwrite && dataadr == exp_adr_q) begin
                            state_d        = (writedata == exp_data_q) ? S_PASS : S_FAIL;
                            fail_timeout_d = 1'b0;
                        end else if (counter == budget_q - TWIDTH'(1)) begin
                            state_d        = S_FAIL;
                            fail_timeout_d = 1'b1;
                        end else begin
                            counter_d = counter + TWIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            counter      <= '0;
            fail_timeout <= 1'b0;
            budget_q     <= TWIDTH'(1);
            exp_adr_q    <= '0;
            exp_data_q   <= '0;
        end else begin
            state        <= state_d;
            counter      <= counter_d;
            fail_timeout <= fail_timeout_d;
            if (load_exp) begin
                // A zero budget behaves as a one-cycle window.
                budget_q   <= (budget == '0) ? TWIDTH'(1) : budget;
                exp_adr_q  <= exp_adr;
                exp_data_q <= exp_data;
            end
        end
    end

    assign status = state;

endmodule

// File: tb/tb_computer_trace_monitor.sv
// Scoreboard bench for computer_trace_monitor: trace readout checked by a
// monitor against a queue of expected entries, checker status checked directly.
module tb_computer_trace_monitor;

    localparam int DWIDTH = 8;
    localparam int IWIDTH = 16;
    localparam int DEPTH  = 16;
    localparam int TWIDTH = 10;
`ifdef TRACE_INSTR_EN
    localparam int ENTRY_W = 3*DWIDTH + IWIDTH;
`else
    localparam int ENTRY_W = 3*DWIDTH;
`endif
    localparam int CWIDTH = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               en = 1'b1;
    logic [DWIDTH-1:0]  pc = '0;
    logic [IWIDTH-1:0]  instr = '0;
    logic               memwrite = 1'b0;
    logic [DWIDTH-1:0]  dataadr = '0;
    logic [DWIDTH-1:0]  writedata = '0;
    logic               arm = 1'b0;
    logic [DWIDTH-1:0]  exp_adr = '0;
    logic [DWIDTH-1:0]  exp_data = '0;
    logic [TWIDTH-1:0]  budget = '0;
    logic               clear = 1'b0;
    logic               rd_en = 1'b0;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic [CWIDTH-1:0]  count;
    logic               overflow;
    logic [1:0]         status;
    logic               fail_timeout;

    int checks = 0;
    int errors = 0;
    logic [ENTRY_W-1:0] exp_q[$];
    logic [ENTRY_W-1:0] last_entry;

    computer_trace_monitor #(
        .DWIDTH(DWIDTH), .IWIDTH(IWIDTH), .DEPTH(DEPTH), .TWIDTH(TWIDTH)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .pc(pc), .instr(instr),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .arm(arm), .exp_adr(exp_adr), .exp_data(exp_data), .budget(budget),
        .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overflow(overflow), .status(status),
        .fail_timeout(fail_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input logic [7:0] p, input logic [7:0] a, input logic [7:0] d);
`ifdef TRACE_INSTR_EN
        return {p, {8'hA5, p}, a, d};
`else
        return {p, a, d};
`endif
    endfunction

    // Monitor: every presented trace entry is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got %0h expected no output", rd_data);
            end else begin
                check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [7:0] p, input logic [7:0] a, input logic [7:0] d, input bit expect_it);
        pc = p; instr = {8'hA5, p}; dataadr = a; writedata = d; memwrite = 1'b1;
        if (expect_it) exp_q.push_back(mk(p, a, d));
        tick();
        memwrite = 1'b0;
    endtask

    task automatic do_arm(input logic [7:0] a, input logic [7:0] d, input logic [TWIDTH-1:0] b);
        exp_adr = a; exp_data = d; budget = b; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_count", 64'(count), 0);
        check("rst_rd_valid", 64'(rd_valid), 0);
        check("rst_rd_data", 64'(rd_data), 0);
        check("rst_status", 64'(status), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_fail_timeout", 64'(fail_timeout), 0);
        reset = 1'b1;
        tick();

        // Matching store 84<-7 ten cycles after arm -> PASS
        do_arm(8'd84, 8'd7, 10'd100);
        check("armed", 64'(status), 2'b01);
        repeat (9) tick();
        store(8'd10, 8'd84, 8'd7, 1'b1);
        check("pass_status", 64'(status), 2'b10);
        check("pass_count", 64'(count), 1);
        pop_n(1);
        tick();
        check("rd_valid_one_cycle", 64'(rd_valid), 0);
        do_clear();
        check("clear_to_idle", 64'(status), 2'b00);

        // Store to another address leaves ARMED; wrong data -> FAIL_DATA
        do_arm(8'd84, 8'd7, 10'd100);
        store(8'd20, 8'd80, 8'd7, 1'b1);
        check("other_adr_armed", 64'(status), 2'b01);
        store(8'd21, 8'd84, 8'd5, 1'b1);
        check("fail_data_status", 64'(status), 2'b11);
        check("fail_data_flag", 64'(fail_timeout), 0);
        check("fail_data_count", 64'(count), 2);
        pop_n(2);
        do_clear();

        // Timeout exactly five cycles after arm
        do_arm(8'd84, 8'd7, 10'd5);
        repeat (4) tick();
        check("timeout_not_yet", 64'(status), 2'b01);
        tick();
        check("timeout_status", 64'(status), 2'b11);
        check("timeout_flag", 64'(fail_timeout), 1);
        // arm outside IDLE is ignored
        do_arm(8'd1, 8'd1, 10'd50);
        check("arm_ignored", 64'(status), 2'b11);
        do_clear();
        check("timeout_clear", 64'(status), 2'b00);
        check("timeout_flag_clear", 64'(fail_timeout), 0);

        // budget=0 behaves as 1
        do_arm(8'd84, 8'd7, 10'd0);
        check("b0_armed", 64'(status), 2'b01);
        tick();
        check("b0_timeout", 64'(status), 2'b11);
        // clear and arm together: clear wins
        clear = 1'b1; arm = 1'b1;
        tick();
        clear = 1'b0; arm = 1'b0;
        check("clear_beats_arm", 64'(status), 2'b00);

        // en=0 freezes counter and blocks pushes
        do_arm(8'd84, 8'd7, 10'd2);
        en = 1'b0;
        store(8'd30, 8'd84, 8'd7, 1'b0);
        repeat (2) tick();
        check("en0_status", 64'(status), 2'b01);
        check("en0_no_push", 64'(count), 0);
        en = 1'b1;
        tick();
        check("en1_counting", 64'(status), 2'b01);
        tick();
        check("en1_timeout", 64'(status), 2'b11);
        do_clear();

        // 17 stores into 16 entries: last one dropped, overflow set
        for (int i = 1; i <= 17; i++)
            store(8'(i), 8'(8'h40 + i), 8'(i * 3), i <= 16);
        check("full_count", 64'(count), 16);
        check("overflow_set", 64'(overflow), 1);
        pop_n(16);
        check("drained_count", 64'(count), 0);
        check("overflow_sticky", 64'(overflow), 1);
        tick();
        check("drained_rd_valid", 64'(rd_valid), 0);
        last_entry = mk(8'd16, 8'h50, 8'd48);
        pop_n(1);
        check("empty_pop_rd_valid", 64'(rd_valid), 0);
        check("empty_pop_rd_data_holds", 64'(rd_data), 64'(last_entry));
        do_clear();
        check("overflow_cleared", 64'(overflow), 0);

        // Full FIFO with push and pop together: no drop, oldest out
        for (int i = 21; i <= 36; i++)
            store(8'(i), 8'(i), 8'(i * 3), 1'b1);
        check("refill_count", 64'(count), 16);
        rd_en = 1'b1;
        store(8'd37, 8'd37, 8'd111, 1'b1);
        rd_en = 1'b0;
        check("full_pushpop_count", 64'(count), 16);
        check("full_pushpop_overflow", 64'(overflow), 0);
        pop_n(16);
        check("refill_drained", 64'(count), 0);

        // Empty FIFO with push and pop together: push accepted, pop ignored
        rd_en = 1'b1;
        store(8'd40, 8'd41, 8'd42, 1'b1);
        rd_en = 1'b0;
        check("empty_pushpop_count", 64'(count), 1);
        check("empty_pushpop_rd_valid", 64'(rd_valid), 0);
        pop_n(1);
        tick();

        // Asynchronous reset while ARMED and mid-readout
        do_arm(8'd84, 8'd7, 10'd100);
        store(8'd50, 8'd1, 8'd11, 1'b1);
        store(8'd51, 8'd2, 8'd12, 1'b0);
        store(8'd52, 8'd3, 8'd13, 1'b0);
        check("pre_reset_count", 64'(count), 3);
        check("pre_reset_status", 64'(status), 2'b01);
        rd_en = 1'b1;
        tick();
        check("pre_reset_rd_valid", 64'(rd_valid), 1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_status", 64'(status), 2'b00);
        check("async_count", 64'(count), 0);
        check("async_rd_valid", 64'(rd_valid), 0);
        rd_en = 1'b0;
        #10;
        reset = 1'b1;
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
